// File: rtl/lut_loader.sv
// Streams the LUT image into the SR lookup-table bank as word pairs over its
// dual-port write interface, then flags load_done for the SR datapath.
module lut_loader #(
  parameter int unsigned DEPTH    = 3392,
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter int unsigned ADDR_OFS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  output logic          LUT_WE,
  output logic          load_busy,
  output logic          load_done,
  output logic [DW-1:0] lut_csum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_start;
  logic          w_accept;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_data1;
  logic [DW-1:0] r_data2;
  logic [AW-1:0] r_addr1;
  logic [AW-1:0] r_addr2;
  logic          r_wr_pend;
  logic          r_lut_we_n;
  logic          r_in_ready;
  logic          r_load_busy;
  logic          r_load_done;
  logic [DW-1:0] r_csum;

  // Next-state logic; in_ready is only ever high in LOAD, so accept needs no count compare.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          w_start = 1'b1;
          w_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_accept = in_valid && r_in_ready;
        if (w_accept && (r_cnt == AW'(DEPTH - 1))) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!r_lut_we_n) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, pairing and write pipeline; data is launched one cycle ahead of addr/WE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_wr_pend   <= 1'b0;
      r_lut_we_n  <= 1'b1;
      r_in_ready  <= 1'b0;
      r_load_busy <= 1'b0;
      r_load_done <= 1'b0;
      r_csum      <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_LOAD);
      r_load_busy <= (w_next == S_LOAD);
      if (w_start) begin
        r_cnt       <= '0;
        r_csum      <= '0;
        r_load_done <= 1'b0;
      end else if ((r_state == S_FLUSH) && !r_lut_we_n) begin
        r_load_done <= 1'b1;
      end
      if (w_accept) begin
        r_cnt  <= r_cnt + AW'(1);
        r_csum <= r_csum ^ in_data;
        if (!r_cnt[0]) begin
          r_hold <= in_data;
        end else begin
          r_data1 <= r_hold;
          r_data2 <= in_data;
        end
      end
      r_wr_pend  <= w_accept && r_cnt[0];
      r_lut_we_n <= !r_wr_pend;
      // r_cnt already points past the pair here, hence the -2/-1.
      if (r_wr_pend) begin
        r_addr1 <= r_cnt - AW'(2) + AW'(ADDR_OFS);
        r_addr2 <= r_cnt - AW'(1) + AW'(ADDR_OFS);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign data1     = r_data1;
  assign data2     = r_data2;
  assign addr1     = r_addr1;
  assign addr2     = r_addr2;
  assign LUT_WE    = r_lut_we_n;
  assign load_busy = r_load_busy;
  assign load_done = r_load_done;
  assign lut_csum  = r_csum;

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: full, throttled, restarted and reset-interrupted
// loads, with a write-sequence monitor and hand-derived expectations.
module tb_lut_loader;

  localparam int unsigned DEPTH = 3392;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned OFS   = 4;
  localparam logic [31:0] BASE  = 32'hA000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic          LUT_WE;
  logic          load_busy;
  logic          load_done;
  logic [DW-1:0] lut_csum;

  always #5 clk = ~clk;

  lut_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ADDR_OFS(OFS)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data1(data1), .data2(data2), .addr1(addr1), .addr2(addr2),
    .LUT_WE(LUT_WE), .load_busy(load_busy), .load_done(load_done),
    .lut_csum(lut_csum)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write-cycle monitor: pair k must be written to 2k+OFS/2k+1+OFS with its data
  // present exactly one cycle earlier, and never in two consecutive cycles.
  int            wr_total = 0;
  int            seq_bad  = 0;
  int            mk       = 0;
  logic          p_we     = 1'b1;
  logic          p_busy   = 1'b0;
  logic [31:0]   p_d1 = '0, p_d2 = '0, pp_d1 = '0, pp_d2 = '0;
  logic [AW-1:0] p_a1 = '0;

  always @(negedge clk) begin
    if (load_busy && !p_busy) mk = 0;
    if (LUT_WE == 1'b0) begin
      wr_total++;
      if (p_we == 1'b0) seq_bad++;
      if (addr1 != AW'(2 * mk + OFS) || addr2 != AW'(2 * mk + 1 + OFS)) seq_bad++;
      if (data1 != BASE + 32'(2 * mk) || data2 != BASE + 32'(2 * mk + 1)) seq_bad++;
      if (p_d1 != data1 || p_d2 != data2) seq_bad++;
      if (pp_d1 == data1 && pp_d2 == data2) seq_bad++;
      if (p_a1 == addr1) seq_bad++;
      mk++;
    end
    pp_d1 = p_d1; pp_d2 = p_d2;
    p_d1 = data1; p_d2 = data2; p_a1 = addr1;
    p_we = LUT_WE; p_busy = load_busy;
  end

  task automatic pulse_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  // Streams words first..last; returns at the negedge after the last accept with in_valid low.
  task automatic send(input int first, input int last, input int duty, input bit probe,
                      input int restart_at);
    int i = first;
    bit acc = 1'b0;
    bit fired = 1'b0;
    int budget = 0;
    while (1) begin
      @(negedge clk);
      load_start = 1'b0;
      if (acc) i++;
      if (probe && acc && i == 2) begin
        chk("pair0_data1", data1, BASE);
        chk("pair0_data2", data2, BASE + 32'd1);
      end
      if (probe && acc && i == 3) begin
        chk("pair0_addr1", 32'(addr1), 32'd4);
        chk("pair0_addr2", 32'(addr2), 32'd5);
        chk("pair0_we", 32'(LUT_WE), 32'd0);
      end
      if (i > last) break;
      if (budget++ > 20000) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
      in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      in_data  = BASE + 32'(i);
      if (i == restart_at && !fired) begin
        load_start = 1'b1;
        fired = 1'b1;
      end
      acc = in_valid && in_ready;
    end
    in_valid = 1'b0;
  endtask

  task automatic tail_checks(input int w0, input logic [31:0] exp_csum);
    chk("last_data1", data1, BASE + 32'(DEPTH - 2));
    chk("last_data2", data2, BASE + 32'(DEPTH - 1));
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("last_addr1", 32'(addr1), 32'd3394);
    chk("last_addr2", 32'(addr2), 32'd3395);
    chk("last_we", 32'(LUT_WE), 32'd0);
    chk("done_early", 32'(load_done), 32'd0);
    @(negedge clk);
    chk("done_set", 32'(load_done), 32'd1);
    chk("done_we", 32'(LUT_WE), 32'd1);
    chk("done_busy", 32'(load_busy), 32'd0);
    chk("write_count", 32'(wr_total - w0), 32'(DEPTH / 2));
    chk("csum", lut_csum, exp_csum);
    chk("wr_sequence", 32'(seq_bad), 32'd0);
  endtask

  task automatic idle_traffic(input logic [31:0] exp_csum);
    int w0 = wr_total;
    bit saw_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) saw_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(saw_ready), 32'd0);
    chk("idle_writes", 32'(wr_total - w0), 32'd0);
    chk("idle_csum", lut_csum, exp_csum);
  endtask

  initial begin
    logic [31:0] full_csum;
    int w0;
    full_csum = '0;
    for (int i = 0; i < int'(DEPTH); i++) full_csum ^= BASE + 32'(i);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(LUT_WE), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_addr2", 32'(addr2), 32'd0);
    chk("rst_data1", data1, 32'd0);
    chk("rst_data2", data2, 32'd0);
    chk("rst_csum", lut_csum, 32'd0);
    rst = 1'b0;

    idle_traffic(32'd0);

    // Back-to-back full load.
    pulse_start();
    w0 = wr_total;
    send(0, DEPTH - 1, 100, 1'b1, -1);
    tail_checks(w0, full_csum);

    // Throttled load.
    pulse_start();
    w0 = wr_total;
    send(0, DEPTH - 1, 40, 1'b0, -1);
    tail_checks(w0, full_csum);

    idle_traffic(full_csum);

    // Restart from DONE, with a stray load_start mid-load.
    pulse_start();
    chk("restart_done_clr", 32'(load_done), 32'd0);
    chk("restart_busy", 32'(load_busy), 32'd1);
    chk("restart_csum_clr", lut_csum, 32'd0);
    w0 = wr_total;
    send(0, DEPTH - 1, 100, 1'b1, 500);
    tail_checks(w0, full_csum);

    // Reset just as pair 50 has its data launched.
    pulse_start();
    w0 = wr_total;
    send(0, 101, 100, 1'b0, -1);
    chk("midrst_data2", data2, BASE + 32'd101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we", 32'(LUT_WE), 32'd1);
    chk("midrst_addr1", 32'(addr1), 32'd0);
    chk("midrst_data1", data1, 32'd0);
    chk("midrst_data2_clr", data2, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(load_busy), 32'd0);
    chk("midrst_csum", lut_csum, 32'd0);
    @(negedge clk);
    chk("midrst_writes", 32'(wr_total - w0), 32'd50);

    // Fresh load after reset starts at the first pair.
    pulse_start();
    send(0, 3, 100, 1'b1, -1);
    repeat (3) @(negedge clk);
    chk("post_rst_seq", 32'(seq_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
